conv_pool_sequencer: RTL and testbench

- Sequences one convolution + 2x2 max-pool layer over a raster-scan pixel stream.
- Tracks the row and column of each input pixel and issues per-pixel advance enables to the conv line buffers.
- Flags the cycles on which the conv window and the pool window hold valid data.
- Replaces gated-clock pooling with clock enables.
- Sits between the pixel source and the conv/max_pool datapath; one instance per layer.

---
 rtl/cnn_pkg.sv | 30 +++
 rtl/raster_counter.sv | 46 ++++
 rtl/conv_pool_sequencer.sv | 132 +++++++++++++
 tb/tb_conv_pool_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN layer sequencers.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int K_DEF     = 5;
  localparam int POOL_DEF  = 2;

  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // One spare bit so a counter can hold the dimension itself, not just its last index.
  localparam int CW_DEF = clog2(IMG_W_DEF > IMG_H_DEF ? IMG_W_DEF : IMG_H_DEF) + 1;

endpackage

// File: rtl/raster_counter.sv
// Raster-scan row/col position counter: advances one column per enable, wrapping rows
// and frames; exposes last-column / last-row flags of the current position.
module raster_counter #(
  parameter int W  = 32,
  parameter int H  = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_col_last,
  output logic          o_row_last
);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(H - 1);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_col_last = (r_col == COL_MAX);
  assign o_row_last = (r_row == ROW_MAX);

endmodule

// File: rtl/conv_pool_sequencer.sv
// Sequences one conv + max-pool layer over a raster pixel stream; window/pool flags
// are registered one cycle after accept, and out_ready low stalls acceptance.
module conv_pool_sequencer
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int K     = K_DEF,
  parameter int POOL  = POOL_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pxl_valid,
  output logic          pxl_ready,
  input  logic          out_ready,
  output logic          conv_en,
  output logic          win_valid,
  output logic          pool_en,
  output logic          pool_valid,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          busy,
  output logic          frame_done
);

  localparam logic [CW-1:0] KM1    = CW'(K - 1);
  localparam logic [CW-1:0] POOL_C = CW'(POOL);
  localparam logic [CW-1:0] POOLM1 = CW'(POOL - 1);

  state_t        r_state;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_win_valid;
  logic          r_pool_en;
  logic          r_pool_valid;
  logic          r_busy;
  logic          r_frame_done;

  logic          w_accept;
  logic          w_arm;
  logic [CW-1:0] w_row_next;
  logic [CW-1:0] w_col_next;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_win;
  logic [CW-1:0] w_cr;
  logic [CW-1:0] w_cc;
  logic          w_pool_hit;

  assign pxl_ready = (r_state == ST_RUN) && out_ready;
  assign w_accept  = pxl_valid && pxl_ready;
  assign conv_en   = w_accept;
  assign w_arm     = (r_state == ST_IDLE) && start;

  // Counter holds the position of the pixel about to be accepted.
  raster_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .CW (CW)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_arm),
    .i_en       (w_accept),
    .o_row      (w_row_next),
    .o_col      (w_col_next),
    .o_col_last (w_col_last),
    .o_row_last (w_row_last)
  );

  assign w_win      = (w_row_next >= KM1) && (w_col_next >= KM1);
  assign w_cr       = w_row_next - KM1;
  assign w_cc       = w_col_next - KM1;
  assign w_pool_hit = ((w_cr % POOL_C) == POOLM1) && ((w_cc % POOL_C) == POOLM1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_win_valid  <= 1'b0;
      r_pool_en    <= 1'b0;
      r_pool_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= w_accept && w_win;
      r_pool_en    <= w_accept && w_win;
      r_pool_valid <= w_accept && w_win && w_pool_hit;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_row <= w_row_next;
            r_col <= w_col_next;
            if (w_col_last && w_row_last) begin
              r_state      <= ST_DONE;
              r_frame_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign win_valid  = r_win_valid;
  assign pool_en    = r_pool_en;
  assign pool_valid = r_pool_valid;
  assign row        = r_row;
  assign col        = r_col;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_pool_sequencer.sv
// Bench for conv_pool_sequencer: pixel-index reference model, landmark table, corner sequences.
module tb_conv_pool_sequencer;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int K     = 5;
  localparam int POOL  = 2;
  localparam int CW    = 6;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          pxl_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          pxl_ready, conv_en, win_valid, pool_en, pool_valid, busy, frame_done;
  logic [CW-1:0] row, col;

  always #5 clk = ~clk;

  conv_pool_sequencer #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .K (K), .POOL (POOL), .CW (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pxl_valid  (pxl_valid),
    .pxl_ready  (pxl_ready),
    .out_ready  (out_ready),
    .conv_en    (conv_en),
    .win_valid  (win_valid),
    .pool_en    (pool_en),
    .pool_valid (pool_valid),
    .row        (row),
    .col        (col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    int pix;
    int row;
    int col;
    int win;
    int pool;
  } vec_t;

  vec_t tbl [10];

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0 idle, 1 streaming, 2 finished; m_pix = raster index of next pixel.
  int m_mode = 0;
  int m_pix  = 0;
  int m_row  = 0;
  int m_col  = 0;
  int f_win  = 0;
  int f_pool = 0;
  int f_fd   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic run_cycle(input logic rst_n, input logic s, input logic pv, input logic ordy);
    int   pr, pc, acc_pix;
    logic exp_ready, acc, e_win, e_pool, e_fd;
    reset = rst_n; start = s; pxl_valid = pv; out_ready = ordy;
    #1;
    exp_ready = (m_mode == 1) && ordy;
    acc       = pv && exp_ready;
    chk("pxl_ready", 32'(pxl_ready), 32'(exp_ready));
    chk("conv_en", 32'(conv_en), 32'(acc));
    acc_pix = m_pix;
    pr      = m_pix / IMG_W;
    pc      = m_pix % IMG_W;
    e_win   = acc && (pr >= K - 1) && (pc >= K - 1);
    e_pool  = e_win && (((pr - (K - 1)) % POOL) == POOL - 1) && (((pc - (K - 1)) % POOL) == POOL - 1);
    e_fd    = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_pix = 0; m_row = 0; m_col = 0;
      e_win = 1'b0; e_pool = 1'b0;
    end else if (m_mode == 0) begin
      if (s) begin
        m_mode = 1; m_pix = 0; m_row = 0; m_col = 0;
      end
    end else if (m_mode == 1) begin
      if (acc) begin
        m_row = pr;
        m_col = pc;
        m_pix = m_pix + 1;
        if (m_pix == NPIX) begin
          m_mode = 2;
          e_fd   = 1'b1;
        end
      end
    end else begin
      m_mode = 0;
    end
    @(posedge clk);
    #1;
    chk("win_valid", 32'(win_valid), 32'(e_win));
    chk("pool_en", 32'(pool_en), 32'(e_win));
    chk("pool_valid", 32'(pool_valid), 32'(e_pool));
    chk("row", 32'(row), 32'(m_row));
    chk("col", 32'(col), 32'(m_col));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    f_win  = f_win + (win_valid === 1'b1 ? 1 : 0);
    f_pool = f_pool + (pool_valid === 1'b1 ? 1 : 0);
    f_fd   = f_fd + (frame_done === 1'b1 ? 1 : 0);
    if (acc && rst_n) begin
      foreach (tbl[i]) begin
        if (tbl[i].pix == acc_pix) begin
          chk("tbl_row", 32'(row), 32'(tbl[i].row));
          chk("tbl_col", 32'(col), 32'(tbl[i].col));
          chk("tbl_win", 32'(win_valid), 32'(tbl[i].win));
          chk("tbl_pool", 32'(pool_valid), 32'(tbl[i].pool));
        end
      end
    end
  endtask

  task automatic run_frame(input bit rnd, input int start_at, input bit start_in_done,
                           input int reset_at, input int exp_fd);
    int   guard;
    bit   rows_checked;
    logic s, rn, pv, ordy;
    f_win = 0; f_pool = 0; f_fd = 0;
    rows_checked = 1'b0;
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    guard = 0;
    while (m_mode != 0 && guard < 20000) begin
      pv   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ordy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s    = (m_mode == 1 && m_pix == start_at) || (m_mode == 2 && start_in_done);
      rn   = !(m_mode == 1 && m_pix == reset_at);
      run_cycle(rn, s, pv, ordy);
      if (!rows_checked && m_pix >= (K - 1) * IMG_W) begin
        rows_checked = 1'b1;
        chk("no_win_rows_0_3", 32'(f_win), 32'd0);
      end
      guard = guard + 1;
    end
    chk("frame_timeout", 32'(guard < 20000), 32'd1);
    chk("frame_done_count", 32'(f_fd), 32'(exp_fd));
    if (reset_at < 0) begin
      chk("win_count", 32'(f_win), 32'd784);
      chk("pool_count", 32'(f_pool), 32'd196);
    end
  endtask

  initial begin
    tbl[0] = '{31, 0, 31, 0, 0};
    tbl[1] = '{32, 1, 0, 0, 0};
    tbl[2] = '{131, 4, 3, 0, 0};
    tbl[3] = '{132, 4, 4, 1, 0};
    tbl[4] = '{164, 5, 4, 1, 0};
    tbl[5] = '{165, 5, 5, 1, 1};
    tbl[6] = '{198, 6, 6, 1, 0};
    tbl[7] = '{231, 7, 7, 1, 1};
    tbl[8] = '{996, 31, 4, 1, 0};
    tbl[9] = '{1023, 31, 31, 1, 1};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pxl_ready", 32'(pxl_ready), 32'd0);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_pool_en", 32'(pool_en), 32'd0);
    chk("rst_pool_valid", 32'(pool_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_col", 32'(col), 32'd0);

    // Idle with a pixel offered but no start: nothing may be accepted.
    repeat (10) run_cycle(1'b1, 1'b0, 1'b1, 1'b1);

    run_frame(1'b0, -1, 1'b0, -1, 1);
    run_frame(1'b1, -1, 1'b0, -1, 1);

    // Row wrap with stalls straddling the boundary.
    run_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (IMG_W) run_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("wrap_row_before", 32'(row), 32'd0);
    chk("wrap_col_before", 32'(col), 32'd31);
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("stall_row_hold", 32'(row), 32'd0);
    chk("stall_col_hold", 32'(col), 32'd31);
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("wrap_row_after", 32'(row), 32'd1);
    chk("wrap_col_after", 32'(col), 32'd0);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset while pixel (10,7) is offered, then a clean frame.
    run_frame(1'b0, -1, 1'b0, 10 * IMG_W + 7, 0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_row", 32'(row), 32'd0);
    chk("midrst_col", 32'(col), 32'd0);
    f_fd = 0;
    repeat (4) run_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("midrst_no_frame_done", 32'(f_fd), 32'd0);
    run_frame(1'b0, -1, 1'b0, -1, 1);

    // start during (3,3) and during DONE is ignored; next frame starts right after DONE.
    run_frame(1'b0, 3 * IMG_W + 3, 1'b1, -1, 1);
    run_frame(1'b1, -1, 1'b0, -1, 1);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
